// File: rtl/event_pulse_shaper_pkg.sv
// event_pulse_shaper_pkg
// Shared types and defaults for the event pulse shaper and its pending counter.
// The optional event queue is enabled with EVENT_PULSE_SHAPER_QUEUE_EN.
package event_pulse_shaper_pkg;

  // Phase of the output pulse generator
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Default pulse high time in clock cycles (legal 1..255)
  localparam int HIGH_CLKS_DEF   = 25;
  // Default minimum low gap after each pulse in clock cycles (legal 1..255)
  localparam int LOW_CLKS_DEF    = 50;
  // Default maximum number of pending events (legal 1..255)
  localparam int QUEUE_DEPTH_DEF = 7;
  // Width of the phase counter; covers the full 1..255 timing range
  localparam int CNT_W           = 8;

  // Width needed to hold a pending count of 0..depth
  function automatic int pend_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter
// Saturating up/down counter used as the pending-event counter.
// inc and dec in the same cycle cancel (net zero). An increment at MAX is
// dropped and flagged on ovf for exactly one cycle. A decrement at zero is
// ignored. Optional block of event_pulse_shaper (EVENT_PULSE_SHAPER_QUEUE_EN).
module sat_updown_counter
  import event_pulse_shaper_pkg::*;
#(
  parameter int MAX = QUEUE_DEPTH_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       inc,
  input  logic                       dec,
  output logic [pend_width(MAX)-1:0] count,
  output logic                       ovf
);

  localparam int W = pend_width(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Count update with saturation and a registered one-cycle overflow flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (inc && !dec) begin
        if (count == MAX_V) begin
          ovf <= 1'b1;
        end else begin
          count <= count + W'(1);
        end
      end else if (dec && !inc) begin
        if (count != '0) begin
          count <= count - W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/event_pulse_shaper.sv
// event_pulse_shaper
// Turns single-cycle event strobes into pulses HIGH_CLKS long, each followed
// by at least LOW_CLKS low cycles. With EVENT_PULSE_SHAPER_QUEUE_EN defined,
// events arriving during a pulse or gap are queued in a saturating pending
// counter and replayed back to back; without it such events are discarded
// and flagged on OVERFLOW.
//
// Handshake: EVENT has no ready; every cycle EVENT is high is one event.
// It is either accepted (starts a pulse or is queued) or discarded, and a
// discard raises OVERFLOW for the following cycle. All outputs come from
// registers, so EVENT never reaches an output combinationally.
//
// state_dbg / pending_dbg expose the FSM state and pending count.
module event_pulse_shaper
  import event_pulse_shaper_pkg::*;
#(
  parameter int HIGH_CLKS   = HIGH_CLKS_DEF,
  parameter int LOW_CLKS    = LOW_CLKS_DEF,
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               EVENT,
  output logic                               PULSE_OUT,
  output logic                               BUSY,
  output logic                               OVERFLOW,
  output state_t                             state_dbg,
  output logic [pend_width(QUEUE_DEPTH)-1:0] pending_dbg
);

  localparam int PEND_W = pend_width(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HIGH_CLKS - 1);
  localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LOW_CLKS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               pulse_q;
  logic [PEND_W-1:0]  pending;
  logic               gap_end;
  logic               pend_nz;

  // Last cycle of the low gap: the point where the next pulse may start
  assign gap_end = (state == ST_GAP) && (cnt == LO_LAST);
  assign pend_nz = (pending != '0);

`ifdef EVENT_PULSE_SHAPER_QUEUE_EN
  logic pend_inc;
  logic pend_dec;
  logic pend_ovf;

  // An event during a pulse or gap is queued. At the gap end it is queued
  // only when a pending event is being consumed at the same time; otherwise
  // it starts the next pulse directly and never touches the counter.
  assign pend_inc = EVENT && ((state == ST_HIGH) ||
                              ((state == ST_GAP) && (!gap_end || pend_nz)));
  // A pending event is consumed when the gap ends and it starts a pulse
  assign pend_dec = gap_end && pend_nz;

  sat_updown_counter #(
    .MAX (QUEUE_DEPTH)
  ) u_pending (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (pend_inc),
    .dec   (pend_dec),
    .count (pending),
    .ovf   (pend_ovf)
  );

  assign OVERFLOW = pend_ovf;
`else
  logic overflow_q;

  // No queue: the pending count is permanently zero
  assign pending = '0;

  // Flag events that arrive while a pulse or gap is running (gap end excluded)
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= EVENT && ((state == ST_HIGH) ||
                              ((state == ST_GAP) && !gap_end));
    end
  end

  assign OVERFLOW = overflow_q;
`endif

  // Pulse FSM with phase counter; pulse_q is registered alongside the state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (EVENT) begin
            state   <= ST_HIGH;
            pulse_q <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt == HI_LAST) begin
            state   <= ST_GAP;
            cnt     <= '0;
            pulse_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            cnt <= '0;
            if (pend_nz || EVENT) begin
              state   <= ST_HIGH;
              pulse_q <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign PULSE_OUT   = pulse_q;
  // Busy until the FSM is idle with nothing left to replay
  assign BUSY        = (state != ST_IDLE) || pend_nz;
  assign state_dbg   = state;
  assign pending_dbg = pending;

endmodule
